pb_pulse_gen: RTL and testbench



---
 rtl/pb_pulse_gen.sv | 111 +++++++++++
 tb/tb_pb_pulse_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pb_pulse_gen.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, one-cycle press pulse
// and optional auto-repeat while the button is held.
`timescale 1ns/1ps
module pb_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic BTN,
  output logic pulse,
  output logic level
);

  localparam int unsigned CntW   = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RptW   = ($clog2(RptMax) > 0) ? $clog2(RptMax) : 1;

  localparam logic [CntW-1:0] CntLast   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RptW-1:0] DelayLast = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RateLast  = RptW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    StIdle        = 2'b00,
    StPressWait   = 2'b01,
    StPressed     = 2'b10,
    StReleaseWait = 2'b11
  } state_e;

  state_e          state_q;
  logic            s1_q, s2_q;
  logic [CntW-1:0] cnt_q;
  logic [RptW-1:0] rpt_q;
  logic            rpt_first_q;
  logic [RptW-1:0] rpt_term;

  assign rpt_term = rpt_first_q ? DelayLast : RateLast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= BTN;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rpt_q       <= '0;
      rpt_first_q <= 1'b0;
      pulse       <= 1'b0;
      level       <= 1'b0;
    end else begin
      pulse <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s2_q) begin
            state_q <= StPressWait;
            cnt_q   <= '0;
          end
        end
        StPressWait: begin
          if (!s2_q) begin
            state_q <= StIdle;
          end else if (cnt_q == CntLast) begin
            state_q     <= StPressed;
            pulse       <= 1'b1;
            level       <= 1'b1;
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StPressed: begin
          if (!s2_q) begin
            // rpt is held so a release bounce only stretches the repeat interval
            state_q <= StReleaseWait;
            cnt_q   <= '0;
          end else if (REPEAT_EN) begin
            if (rpt_q == rpt_term) begin
              pulse       <= 1'b1;
              rpt_q       <= '0;
              rpt_first_q <= 1'b0;
            end else begin
              rpt_q <= rpt_q + 1'b1;
            end
          end
        end
        StReleaseWait: begin
          if (s2_q) begin
            state_q <= StPressed;
          end else if (cnt_q == CntLast) begin
            state_q <= StIdle;
            level   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pb_pulse_gen.sv
// Directed bench for pb_pulse_gen: one instance without and one with auto-repeat,
// both driven by the same button and reset.
`timescale 1ns/1ps
module tb_pb_pulse_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic pulse0, level0, pulse1, level1;
  int   checks = 0;
  int   failures = 0;
  int   np0 = 0;
  int   np1 = 0;
  int   base;

  always #5 clk = ~clk;

  pb_pulse_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(10), .REPEAT_RATE(5)
  ) dut0 (
    .clk(clk), .rst(rst), .BTN(btn), .pulse(pulse0), .level(level0)
  );

  pb_pulse_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(10), .REPEAT_RATE(5)
  ) dut1 (
    .clk(clk), .rst(rst), .BTN(btn), .pulse(pulse1), .level(level1)
  );

  always @(posedge clk) begin
    if (pulse0 === 1'b1) np0++;
    if (pulse1 === 1'b1) np1++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_pulse0", pulse0, 1'b0);
    check("rst_level0", level0, 1'b0);
    check("rst_pulse1", pulse1, 1'b0);
    check("rst_level1", level1, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    step();

    // Clean press: E0 samples 1, pulse/level rise at E6
    base = np0;
    btn = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) begin
      step();
      check("press_wait_pulse", pulse0, 1'b0);
      check("press_wait_level", level0, 1'b0);
    end
    step();
    check("press_pulse0", pulse0, 1'b1);
    check("press_level0", level0, 1'b1);
    check("press_pulse1", pulse1, 1'b1);
    for (int k = 7; k <= 20; k++) begin
      step();
      check("held_pulse0", pulse0, 1'b0);
      check("held_level0", level0, 1'b1);
    end
    // Release: level falls 6 edges after first sample of 0
    btn = 1'b0;
    step();
    for (int k = 1; k <= 5; k++) begin
      step();
      check("release_level", level0, 1'b1);
      check("release_pulse", pulse0, 1'b0);
    end
    step();
    check("release_level_low", level0, 1'b0);
    check("release_level1_low", level1, 1'b0);
    step();
    check_int("clean_press_count", np0 - base, 1);

    // Bounce rejection: 1,0,1,0,1 then held; pulse 6 edges after final rising sample
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      btn = (k % 2 == 0);
      step();
      check("bounce_pulse", pulse0, 1'b0);
    end
    btn = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) begin
      step();
      check("bounce_wait_pulse", pulse0, 1'b0);
      check("bounce_wait_level", level0, 1'b0);
    end
    step();
    check("bounce_pulse_out", pulse0, 1'b1);
    check("bounce_level_out", level0, 1'b1);
    btn = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check("bounce_released", level0, 1'b0);
    check("bounce_released1", level1, 1'b0);

    // Glitches: 1-cycle spikes every 3 cycles never qualify
    for (int k = 0; k < 30; k++) begin
      btn = (k % 3 == 0);
      step();
      check("glitch_pulse0", pulse0, 1'b0);
      check("glitch_level0", level0, 1'b0);
      check("glitch_pulse1", pulse1, 1'b0);
      check("glitch_level1", level1, 1'b0);
    end
    btn = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // Auto-repeat: press pulse at P, repeats at P+10 then every 5
    base = np0;
    btn = 1'b1;
    step();
    for (int k = 1; k <= 6; k++) step();
    check("rpt_press_pulse", pulse1, 1'b1);
    for (int k = 1; k <= 42; k++) begin
      step();
      check("rpt_pulse", pulse1, (k >= 10 && k % 5 == 0));
      check("rpt_level", level1, 1'b1);
    end
    check_int("norpt_count", np0 - base, 1);
    // Release bounce: 2 low samples at P+43/P+44 freeze rpt for 3 edges
    btn = 1'b0;
    step();
    step();
    btn = 1'b1;
    for (int k = 45; k <= 55; k++) begin
      step();
      check("rbounce_pulse", pulse1, (k == 48 || k == 53));
      check("rbounce_level", level1, 1'b1);
    end
    btn = 1'b0;
    for (int k = 56; k <= 66; k++) begin
      step();
      check("rpt_release_pulse", pulse1, 1'b0);
    end
    check("rpt_release_level", level1, 1'b0);

    // Async reset mid-PRESS_WAIT, applied between edges
    btn = 1'b1;
    for (int k = 0; k < 4; k++) step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_pulse", pulse1, 1'b0);
    check("arst_level", level1, 1'b0);
    check("arst_state", logic'(dut1.state_q != 2'b00), 1'b0);
    step();
    rst = 1'b0;
    step();
    for (int k = 1; k <= 5; k++) begin
      step();
      check("arst_wait_pulse", pulse1, 1'b0);
    end
    step();
    check("arst_press_pulse0", pulse0, 1'b1);
    check("arst_press_pulse1", pulse1, 1'b1);
    check("arst_press_level1", level1, 1'b1);
    step();
    check("arst_pulse_fall", pulse1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
